// File: rtl/csr_wb_pipe.sv
// CSR write-back pipe: a two-entry in-order buffer between EXE and WB that
// holds pending CSR results. Pending writes are forwarded to younger readers.
module csr_wb_pipe #(
  parameter int RSZ   = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic           flush,
  input  logic           exe_valid,
  output logic           exe_ready,
  input  logic           csr_wr,
  input  logic [11:0]    csr_addr,
  input  logic [RSZ-1:0] csr_wr_data,
  input  logic [RSZ-1:0] nxt_csr_rd_data,
  input  logic           ill_csr_access,
  output logic           wb_valid,
  input  logic           wb_ready,
  output logic           wb_csr_wr,
  output logic [11:0]    wb_csr_addr,
  output logic [RSZ-1:0] wb_csr_wr_data,
  output logic           wb_ill_csr_access,
  input  logic [11:0]    fwd_addr,
  output logic           fwd_hit,
  output logic [RSZ-1:0] fwd_data,
  output logic [1:0]     pend_cnt
);

  typedef struct packed {
    logic           wr;
    logic [11:0]    addr;
    logic [RSZ-1:0] wdata;
    logic [RSZ-1:0] nxt;
    logic           ill;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;
  logic [1:0] occ;
  logic [1:0] cand;
  logic       young;
  logic       old;
  entry_t     head;

  assign exe_ready = (cnt < 2'(DEPTH)) && !flush;
  assign wb_valid  = (cnt != 2'd0);
  assign push      = exe_valid && exe_ready;
  assign pop       = wb_valid && wb_ready;
  assign pend_cnt  = cnt;

  // Pointer and occupancy bookkeeping; flush drops everything, even a same-cycle push.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{wr: csr_wr, addr: csr_addr, wdata: csr_wr_data,
                       nxt: nxt_csr_rd_data, ill: ill_csr_access};
    end
  end

  // Head presentation; fields read as zero whenever the buffer is empty.
  always_comb begin
    head              = mem[rd_ptr];
    wb_csr_wr         = wb_valid & head.wr;
    wb_csr_addr       = {12{wb_valid}} & head.addr;
    wb_csr_wr_data    = {RSZ{wb_valid}} & head.wdata;
    wb_ill_csr_access = wb_valid & head.ill;
  end

  // Forwarding from buffered legal writes only; the younger match wins.
  always_comb begin
    occ[0]   = (cnt == 2'd2) || ((cnt == 2'd1) && (rd_ptr == 1'b0));
    occ[1]   = (cnt == 2'd2) || ((cnt == 2'd1) && (rd_ptr == 1'b1));
    cand[0]  = occ[0] && mem[0].wr && !mem[0].ill && (mem[0].addr == fwd_addr);
    cand[1]  = occ[1] && mem[1].wr && !mem[1].ill && (mem[1].addr == fwd_addr);
    old      = rd_ptr;
    young    = rd_ptr ^ (cnt == 2'd2);
    fwd_hit  = |cand;
    fwd_data = '0;
    if (cand[young])    fwd_data = mem[young].nxt;
    else if (cand[old]) fwd_data = mem[old].nxt;
  end

endmodule

// File: doc/csr_wb_pipe.md
CSR_WB_PIPE -- requirements
Module: csr_wb_pipe

Interface
REQ-001 Parameter RSZ, default 32, register/CSR data width.
REQ-002 Parameter DEPTH, default 2, entry count; only the value 2 is supported.
REQ-003 clk_in  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_in  input  1  reset, asynchronous and active-high.
REQ-005 flush  input  1  discard all buffered entries (pipeline flush on trap or branch).
REQ-006 exe_valid  input  1  EXE stage presents a CSR result this cycle.
REQ-007 exe_ready  output  1  block can accept an entry this cycle.
REQ-008 csr_wr  input  1  CSR write request from the CSR functional unit.
REQ-009 csr_addr  input  12  CSR address.
REQ-010 csr_wr_data  input  RSZ  data to write to CSR[csr_addr].
REQ-011 nxt_csr_rd_data  input  RSZ  value CSR[csr_addr] will hold after the write.
REQ-012 ill_csr_access  input  1  illegal CSR access flag.
REQ-013 wb_valid  output  1  head entry presented to WB.
REQ-014 wb_ready  input  1  WB consumes the head entry this cycle.
REQ-015 wb_csr_wr, wb_csr_addr, wb_csr_wr_data, wb_ill_csr_access  outputs  1/12/RSZ/1  head entry fields.
REQ-016 fwd_addr  input  12  CSR address being read by a younger EXE instruction.
REQ-017 fwd_hit  output  1  a buffered pending write matches fwd_addr.
REQ-018 fwd_data  output  RSZ  forwarded nxt_csr_rd_data of the matching entry.
REQ-019 pend_cnt  output  2  number of occupied entries (0..2).

Function
REQ-020 Storage: 2-entry in-order FIFO; each entry holds {csr_wr, csr_addr, csr_wr_data, nxt_csr_rd_data, ill_csr_access}.
REQ-021 exe_ready = (pend_cnt < 2) && !flush, combinational.
REQ-022 Push: exe_valid && exe_ready at an edge writes the entry at the tail.
REQ-023 Pop: wb_valid && wb_ready at an edge removes the head.
REQ-024 wb_valid = (pend_cnt != 0); wb_* outputs are driven directly from head registers, with no combinational path from EXE inputs.
REQ-025 Minimum latency: an entry pushed at edge N is visible on wb_* in the cycle after edge N.
REQ-026 Simultaneous push and pop with pend_cnt = 1: head advances, new entry is written, pend_cnt stays 1.
REQ-027 Simultaneous push and pop with pend_cnt = 0 cannot occur because wb_valid = 0.
REQ-028 Full (pend_cnt = 2): exe_ready = 0; a pop that cycle gives pend_cnt 1 next cycle; no same-cycle refill.
REQ-029 When pend_cnt = 0, wb_* data outputs are 0 and the data fields hold no meaning.
REQ-030 Pointers are 1 bit, wrap 1 -> 0; pend_cnt never exceeds 2 and never goes below 0.
REQ-031 Forwarding candidates are occupied entries with csr_wr = 1, ill_csr_access = 0 and csr_addr == fwd_addr.
REQ-032 fwd_hit = OR of the forwarding candidates.
REQ-033 fwd_data = nxt_csr_rd_data of the youngest candidate, else 0; combinational.
REQ-034 Forwarding uses only buffered entries and never the current EXE inputs.
REQ-035 Flush at an edge empties the FIFO: pend_cnt becomes 0 and pointers become 0.
REQ-036 A push in the flush cycle is dropped, because exe_ready = 0 during flush.
REQ-037 A pop in the flush cycle completes: WB has consumed that head.
REQ-038 Illegal entries (ill_csr_access = 1) pass through in order, are never forwarded, and are not altered.

Reset
REQ-039 While reset_in = 1, all state clears asynchronously: pend_cnt = 0, pointers = 0, wb_valid = 0, all wb_* outputs = 0, fwd_hit = 0, fwd_data = 0.
REQ-040 After reset deasserts, exe_ready = 1 from the first cycle unless flush = 1.
REQ-041 Reset asserted mid-operation discards all entries with no WB handshake.

Verification
REQ-042 Push {wr=1, addr=0x300, data=0x8, nxt=0x8} with wb_ready=0 -> next cycle wb_valid=1, wb_csr_addr=0x300, pend_cnt=1; fwd_addr=0x300 gives fwd_hit=1, fwd_data=0x8.
REQ-043 Push 0x340/nxt=0x1 then 0x340/nxt=0x2 with wb_ready=0 -> pend_cnt=2, exe_ready=0, fwd_data=0x2 (youngest); a third push is ignored.
REQ-044 Full, then wb_ready=1 for one cycle -> pend_cnt=1, head addr 0x340 with nxt 0x2, exe_ready=1.
REQ-045 pend_cnt=1 with push and pop in the same cycle, repeated 10 cycles -> pend_cnt stays 1 and WB receives all entries in push order.
REQ-046 pend_cnt=2 with flush=1 and exe_valid=1 -> next cycle pend_cnt=0, wb_valid=0, fwd_hit=0.
REQ-047 Push an ill_csr_access=1 entry with addr 0x305 and fwd_addr=0x305 -> fwd_hit=0; then assert reset_in asynchronously mid-cycle -> wb_valid=0 immediately.
